// File: rtl/cache_control_nway.sv
// Control FSM for a WAYS-way set-associative write-back, write-allocate cache.
// Serves hits in the request cycle and sequences write-back/allocate on misses.
module cache_control_nway #(
    parameter  int unsigned WAYS  = 2,
    parameter  int unsigned CNT_W = 16,
    localparam int unsigned WAY_W = $clog2(WAYS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             hit,
    input  logic [WAY_W-1:0] hit_way,
    input  logic [WAY_W-1:0] victim_way,
    input  logic             victim_valid,
    input  logic             victim_dirty,
    input  logic             pmem_resp,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    output logic             pmem_addr_sel,
    output logic             data_sel,
    output logic [WAYS-1:0]  load_tag,
    output logic [WAYS-1:0]  load_data,
    output logic [WAYS-1:0]  load_valid,
    output logic [WAYS-1:0]  load_dirty,
    output logic             dirty_in,
    output logic             load_lru,
    output logic [WAY_W-1:0] lru_way,
    output logic             busy,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WRITE_BACK = 2'd1,
        ALLOCATE   = 2'd2
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WAY_W-1:0] victim_q;
    logic             prev_idle;
    logic             prev_resp;
    logic             req;
    logic             hit_inc;
    logic             miss_inc;
    logic             wb_inc;
    logic [WAYS-1:0]  hit_onehot;
    logic [WAYS-1:0]  victim_onehot;

    assign req           = mem_read | mem_write;
    assign hit_onehot    = WAYS'(1) << hit_way;
    assign victim_onehot = WAYS'(1) << victim_q;

    // Post-fill hits and back-to-back completions are not recounted as hits.
    assign hit_inc  = (state == IDLE) && req && hit && prev_idle && !prev_resp;
    assign miss_inc = (state == IDLE) && req && !hit;
    assign wb_inc   = (state == WRITE_BACK) && pmem_resp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            victim_q   <= '0;
            prev_idle  <= 1'b1;
            prev_resp  <= 1'b0;
            hit_count  <= '0;
            miss_count <= '0;
            wb_count   <= '0;
        end else begin
            state     <= state_n;
            prev_idle <= (state == IDLE);
            prev_resp <= mem_resp;
            if (miss_inc) begin
                victim_q <= victim_way;
            end
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + CNT_W'(1);
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + CNT_W'(1);
            end
            if (wb_inc && (wb_count != '1)) begin
                wb_count <= wb_count + CNT_W'(1);
            end
        end
    end

    // Next state and datapath strobes; everything but the counters is quiet in reset.
    always_comb begin
        state_n       = state;
        mem_resp      = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        data_sel      = 1'b0;
        load_tag      = '0;
        load_data     = '0;
        load_valid    = '0;
        load_dirty    = '0;
        dirty_in      = 1'b0;
        load_lru      = 1'b0;
        lru_way       = '0;
        busy          = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: begin
                    if (req && hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_way  = hit_way;
                        if (mem_write) begin
                            load_data  = hit_onehot;
                            load_dirty = hit_onehot;
                            dirty_in   = 1'b1;
                        end
                    end else if (req) begin
                        state_n = (victim_valid && victim_dirty) ? WRITE_BACK : ALLOCATE;
                    end
                end
                WRITE_BACK: begin
                    pmem_write    = 1'b1;
                    pmem_addr_sel = 1'b1;
                    if (pmem_resp) begin
                        state_n = ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    pmem_read = 1'b1;
                    if (pmem_resp) begin
                        load_tag   = victim_onehot;
                        load_data  = victim_onehot;
                        load_valid = victim_onehot;
                        load_dirty = victim_onehot;
                        data_sel   = 1'b1;
                        state_n    = IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule
